serial_alu_engine: RTL and testbench

Multi-cycle bit-serial ALU. It computes one WIDTH-bit ALU operation by stepping a single 1-bit ALU slice from LSB to MSB, one bit per clock. It owns the state that the combinational slice chain passes between bits: the carry, the running zero flag and the partial result. It is the sequencing end of the slice's Cin/COut and zin/zout chain, and the area-minimal alternative to the fully unrolled 64-slice ALU in the datapath.

---
 rtl/serial_alu_engine_if.sv | 27 ++
 rtl/serial_alu_engine.sv | 114 +++++++++++
 tb/tb_serial_alu_engine.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_alu_engine_if.sv
// Operand/request and result/flag bundle for the bit-serial ALU.
// master issues operations; slave (the engine) returns busy/done, result and flags.
interface serial_alu_engine_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [2:0]       cntrl;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             negative;
   logic             zero;
   logic             overflow;
   logic             carry_out;

   modport master (
      output start, cntrl, A, B,
      input  busy, done, result, negative, zero, overflow, carry_out
   );

   modport slave (
      input  start, cntrl, A, B,
      output busy, done, result, negative, zero, overflow, carry_out
   );
endinterface

// File: rtl/serial_alu_engine.sv
// Bit-serial ALU stepping one slice LSB->MSB; start-to-done latency WIDTH+1 cycles.
// No backpressure: start is only sampled in IDLE, requests during RUN/DONE are dropped.
module serial_alu_engine #(
   parameter int WIDTH = 64
) (
   input logic                clk,
   input logic                reset,
   serial_alu_engine_if.slave alu
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic [2:0]       op;
   logic [CW-1:0]    cnt;
   logic             carry, zacc;
   logic             beff, sum, carry_nxt, obit, arith;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      alu.busy  = 1'b0;
      alu.done  = 1'b0;
      case (state)
         IDLE: if (alu.start) state_nxt = RUN;
         RUN: begin
            alu.busy = 1'b1;
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            alu.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Single 1-bit ALU slice acting on the current LSBs of the operand shifters.
   always_comb begin
      arith     = (op[2:1] == 2'b01);
      beff      = b_sr[0] ^ op[0];
      sum       = a_sr[0] ^ beff ^ carry;
      carry_nxt = (a_sr[0] & beff) | (a_sr[0] & carry) | (beff & carry);
      obit      = 1'b0;
      case (op)
         3'b000:         obit = b_sr[0];
         3'b010, 3'b011: obit = sum;
         3'b100:         obit = a_sr[0] & b_sr[0];
         3'b101:         obit = a_sr[0] | b_sr[0];
         3'b110:         obit = a_sr[0] ^ b_sr[0];
         default:        obit = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr          <= '0;
         b_sr          <= '0;
         res_sr        <= '0;
         op            <= '0;
         cnt           <= '0;
         carry         <= 1'b0;
         zacc          <= 1'b0;
         alu.result    <= '0;
         alu.negative  <= 1'b0;
         alu.zero      <= 1'b0;
         alu.overflow  <= 1'b0;
         alu.carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (alu.start) begin
                  a_sr  <= alu.A;
                  b_sr  <= alu.B;
                  op    <= alu.cntrl;
                  cnt   <= '0;
                  carry <= (alu.cntrl[2:1] == 2'b01) ? alu.cntrl[0] : 1'b0;
                  zacc  <= 1'b1;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= {obit, res_sr[WIDTH-1:1]};
               carry  <= carry_nxt;
               zacc   <= zacc & ~obit;
               cnt    <= cnt + CW'(1);
               // On the MSB step the carry register still holds the carry into
               // the MSB, so overflow falls out of it directly.
               if (cnt == LAST) begin
                  alu.result    <= {obit, res_sr[WIDTH-1:1]};
                  alu.negative  <= obit;
                  alu.zero      <= zacc & ~obit;
                  alu.carry_out <= arith ? carry_nxt : 1'b0;
                  alu.overflow  <= arith ? (carry ^ carry_nxt) : 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_alu_engine.sv
// Self-checking bench for serial_alu_engine against a whole-word arithmetic model.
module tb_serial_alu_engine;
   localparam int W = 64;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   serial_alu_engine_if #(.WIDTH(W)) alu ();
   serial_alu_engine #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .alu(alu));

   function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic n, output logic z,
                                 output logic v, output logic c);
      logic [W:0] w;
      r = '0; v = 1'b0; c = 1'b0;
      case (op)
         3'b000: r = b;
         3'b010: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[W-1:0]; c = w[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'b011: begin
            w = {1'b0, a} + {1'b0, ~b} + 1;
            r = w[W-1:0]; c = w[W];
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'b100: r = a & b;
         3'b101: r = a | b;
         3'b110: r = a ^ b;
         default: r = '0;
      endcase
      n = r[W-1];
      z = (r == '0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one op from IDLE, scrambles the inputs after acceptance, and checks
   // latency, result, flags and the single-cycle done pulse.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      logic [W-1:0] er;
      logic en, ez, ev, ec;
      int n;
      bit seen;
      bit overlap;
      model(op, a, b, er, en, ez, ev, ec);
      alu.start = 1'b1; alu.cntrl = op; alu.A = a; alu.B = b;
      n = 0; seen = 0; overlap = 0;
      while (!seen && n < 200) begin
         tick();
         n++;
         if (n == 1) begin
            alu.start = 1'b0;
            alu.A = {$urandom, $urandom};
            alu.B = {$urandom, $urandom};
            alu.cntrl = 3'($urandom_range(0, 7));
         end
         if (alu.busy && alu.done) overlap = 1;
         if (alu.done) seen = 1;
      end
      vectors++;
      if (n !== W + 1) begin
         miscompares++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", tag, n, W + 1);
      end
      vectors++;
      if (overlap) begin
         miscompares++;
         $display("FAIL %s busy_done_overlap: got 1, expected 0", tag);
      end
      vectors++;
      if (alu.result !== er) begin
         miscompares++;
         $display("FAIL %s result: got %h, expected %h", tag, alu.result, er);
      end
      vectors++;
      if ({alu.negative, alu.zero, alu.overflow, alu.carry_out} !== {en, ez, ev, ec}) begin
         miscompares++;
         $display("FAIL %s flags nzvc: got %b, expected %b", tag,
                  {alu.negative, alu.zero, alu.overflow, alu.carry_out}, {en, ez, ev, ec});
      end
      tick();
      vectors++;
      if ({alu.busy, alu.done} !== 2'b00 || alu.result !== er) begin
         miscompares++;
         $display("FAIL %s after_done busy/done/result: got %b/%h, expected 00/%h", tag,
                  {alu.busy, alu.done}, alu.result, er);
      end
   endtask

   task automatic test_reset();
      alu.start = 1'b0; alu.cntrl = '0; alu.A = '0; alu.B = '0;
      reset = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({alu.busy, alu.done, alu.negative, alu.zero, alu.overflow, alu.carry_out} !== 6'b0 ||
          alu.result !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got bdnzvc=%b result=%h, expected all 0",
                  {alu.busy, alu.done, alu.negative, alu.zero, alu.overflow, alu.carry_out},
                  alu.result);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      logic [W-1:0] pa, pb;
      pa = {8{8'hF0}};
      pb = {{4{8'hFF}}, {4{8'h00}}};
      run_op("add_5_3", 3'b010, 64'd5, 64'd3);
      run_op("sub_3_5", 3'b011, 64'd3, 64'd5);
      run_op("sub_7_7", 3'b011, 64'd7, 64'd7);
      run_op("add_ovf", 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      run_op("and", 3'b100, pa, pb);
      run_op("or", 3'b101, pa, pb);
      run_op("xor", 3'b110, pa, pb);
      run_op("pass_b", 3'b000, pa, pb);
      run_op("op111", 3'b111, pa, pb);
      run_op("op001", 3'b001, pa, pb);
      run_op("sub_ovf", 3'b011, 64'h8000_0000_0000_0000, 64'd1);
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic [2:0] op;
      for (int i = 0; i < 20; i++) begin
         a = {$urandom, $urandom};
         b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
         op = 3'($urandom_range(0, 7));
         run_op($sformatf("rand%0d", i), op, a, b);
      end
   endtask

   task automatic test_start_while_busy();
      logic [W-1:0] er;
      logic en, ez, ev, ec;
      int dones;
      model(3'b010, 64'd1000, 64'd234, er, en, ez, ev, ec);
      alu.start = 1'b1; alu.cntrl = 3'b010; alu.A = 64'd1000; alu.B = 64'd234;
      tick();
      alu.start = 1'b0;
      dones = 0;
      for (int n = 2; n <= 150; n++) begin
         tick();
         if (n == 11) begin
            alu.start = 1'b1; alu.cntrl = 3'b110; alu.A = '1; alu.B = 64'd77;
         end else begin
            alu.start = 1'b0;
         end
         if (alu.done) begin
            dones++;
            vectors++;
            if (alu.result !== er) begin
               miscompares++;
               $display("FAIL busy_start result: got %h, expected %h", alu.result, er);
            end
            // A start presented during DONE must be dropped.
            alu.start = 1'b1;
            tick();
            n++;
            alu.start = 1'b0;
            vectors++;
            if (alu.busy !== 1'b0) begin
               miscompares++;
               $display("FAIL start_in_done busy: got %b, expected 0", alu.busy);
            end
         end
      end
      vectors++;
      if (dones !== 1) begin
         miscompares++;
         $display("FAIL busy_start done_pulses: got %0d, expected 1", dones);
      end
   endtask

   task automatic test_reset_mid();
      int dones;
      run_op("pre_reset", 3'b011, 64'd3, 64'd5);
      alu.start = 1'b1; alu.cntrl = 3'b010; alu.A = 64'd11; alu.B = 64'd22;
      tick();
      alu.start = 1'b0;
      repeat (30) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if ({alu.busy, alu.done, alu.negative, alu.zero, alu.overflow, alu.carry_out} !== 6'b0 ||
          alu.result !== '0) begin
         miscompares++;
         $display("FAIL reset_mid outputs: got bdnzvc=%b result=%h, expected all 0",
                  {alu.busy, alu.done, alu.negative, alu.zero, alu.overflow, alu.carry_out},
                  alu.result);
      end
      dones = 0;
      repeat (80) begin
         tick();
         if (alu.done) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++;
         $display("FAIL reset_mid done_pulses: got %0d, expected 0", dones);
      end
      run_op("post_reset", 3'b010, 64'd5, 64'd3);
   endtask

   task automatic test_back_to_back();
      run_op("b2b_0", 3'b011, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF);
      run_op("b2b_1", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      run_op("b2b_2", 3'b101, 64'h0, 64'h0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
